adc_scan_scheduler: RTL and testbench

// - Time-multiplexes one single-slope ramp ADC (comparator + integrating cap) across the four colour-sensor channels: red, green, blue, intensity.
// - Sequences the analog mux, cap discharge and ramp count for each channel, and stores a per-channel result.
// - Sits between the sensor front-end and the per-channel pwm drivers. It replaces four free-running converters with one scheduled converter.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/scan_ramp_counter.sv | 37 +++
 rtl/adc_scan_scheduler.sv | 171 +++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan scheduler.
// Channel indices (also the analog mux select codes), the scheduler state
// encoding and the channel count.
package adc_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_GREEN = 2'd1;
    localparam logic [1:0] CH_BLUE  = 2'd2;
    localparam logic [1:0] CH_INT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        RAMP      = 2'd2,
        STORE     = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_ramp_counter.sv
// Tick-enabled saturating ramp counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous clear to 0 (held while not ramping)
//   tick        - ramp-rate strobe, increments the count
//   stop        - comparator has tripped; blocks an increment on the same edge
//   max_val     - full-scale value for the channel being converted
//   count       - current ramp count
//   at_max      - count has reached full scale
module scan_ramp_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic         stop,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == max_val);

    // Saturates at max_val: the scheduler turns a tick at full scale into
    // an overflow store, so the count must never wrap to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !stop && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Schedules one single-slope ramp ADC across the red, green, blue and
// intensity channels of the colour sensor: selects the mux, discharges the
// cap, counts ramp ticks until the comparator trips and stores the result.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   tick            - ramp-rate strobe (only used while ramping)
//   compared_value  - raw asynchronous comparator output
//   start           - one-clock request for a single scan
//   continuous      - level, rescan back-to-back while high
//   chan_en         - channel enables {int, blue, green, red}
//   mux_sel         - analog mux select (current channel)
//   discharge       - 1 shorts the integrating cap
//   busy            - scheduler not idle
//   result_valid    - one-clock pulse when a result is stored
//   result_chan     - channel of the last stored result
//   result_ovf      - last stored result hit full scale
//   scan_done       - one-clock pulse with the last channel's result
//   results         - {intensity, blue, green, red}, red in the LSBs
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int N                = 8,
    parameter int I_BITS           = 6,
    parameter int DISCHARGE_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  compared_value,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [3:0]            chan_en,
    output logic [1:0]            mux_sel,
    output logic                  discharge,
    output logic                  busy,
    output logic                  result_valid,
    output logic [1:0]            result_chan,
    output logic                  result_ovf,
    output logic                  scan_done,
    output logic [3*N+I_BITS-1:0] results
);

    localparam int DW = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [N-1:0] INT_MAX = N'((1 << I_BITS) - 1);

    scan_state_t   state;
    logic [3:0]    en_lat;
    logic [DW-1:0] dis_cnt;
    logic          comp_m, comp_s;
    logic [N-1:0]  count, max_val;
    logic          at_max;
    logic          store_now;
    logic [1:0]    first_ch, restart_ch, next_ch;
    logic          next_found;

    // Two-flop synchroniser on the asynchronous comparator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_m <= 1'b0;
            comp_s <= 1'b0;
        end else begin
            comp_m <= compared_value;
            comp_s <= comp_m;
        end
    end

    assign max_val   = (mux_sel == CH_INT) ? INT_MAX : {N{1'b1}};
    assign store_now = (state == RAMP) && (comp_s || (tick && at_max));

    // Held clear outside RAMP, so every ramp starts from 0.
    scan_ramp_counter #(.W(N)) u_ramp (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RAMP),
        .tick    (tick),
        .stop    (comp_s),
        .max_val (max_val),
        .count   (count),
        .at_max  (at_max)
    );

    // Channel priority picks: lowest enabled for a new scan (live enables),
    // lowest latched for a continuous restart, next higher latched otherwise.
    always_comb begin
        first_ch   = 2'd0;
        restart_ch = 2'd0;
        next_ch    = 2'd0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_en[i]) first_ch = 2'(i);
            if (en_lat[i]) restart_ch = 2'(i);
            if (en_lat[i] && (2'(i) > mux_sel)) begin
                next_ch    = 2'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            discharge    <= 1'b1;
            mux_sel      <= 2'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_chan  <= 2'd0;
            result_ovf   <= 1'b0;
            scan_done    <= 1'b0;
            results      <= '0;
            en_lat       <= 4'd0;
            dis_cnt      <= '0;
        end else begin
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
            case (state)
                IDLE: begin
                    discharge <= 1'b1;
                    if ((start || continuous) && (chan_en != 4'd0)) begin
                        en_lat  <= chan_en;
                        mux_sel <= first_ch;
                        dis_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= DISCHARGE;
                    end
                end
                DISCHARGE: begin
                    if (dis_cnt == DW'(DISCHARGE_CYCLES - 1)) begin
                        discharge <= 1'b0;
                        state     <= RAMP;
                    end else begin
                        dis_cnt <= dis_cnt + DW'(1);
                    end
                end
                RAMP: begin
                    if (store_now) begin
                        // Comparator has priority: an overflow is only
                        // flagged when a tick arrives at full scale untripped.
                        case (mux_sel)
                            CH_RED:   results[N-1:0]             <= count;
                            CH_GREEN: results[2*N-1:N]           <= count;
                            CH_BLUE:  results[3*N-1:2*N]         <= count;
                            CH_INT:   results[3*N+I_BITS-1:3*N]  <= count[I_BITS-1:0];
                            default:  ;
                        endcase
                        result_chan  <= mux_sel;
                        result_ovf   <= !comp_s;
                        result_valid <= 1'b1;
                        scan_done    <= !next_found;
                        discharge    <= 1'b1;
                        state        <= STORE;
                    end
                end
                STORE: begin
                    dis_cnt <= '0;
                    if (next_found) begin
                        mux_sel <= next_ch;
                        state   <= DISCHARGE;
                    end else if (continuous && (en_lat != 4'd0)) begin
                        mux_sel <= restart_ch;
                        state   <= DISCHARGE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler (N=8, I_BITS=6,
// DISCHARGE_CYCLES=4, tick every 4 clocks). A sensor model raises the
// comparator after a chosen number of ramp ticks per channel; a reference
// model predicts each stored code from that threshold and full scale.
module tb_adc_scan_scheduler;

    localparam int N      = 8;
    localparam int I_BITS = 6;
    localparam int DC     = 4;
    localparam int RW     = 3 * N + I_BITS;
    localparam int NMAX   = (1 << N) - 1;
    localparam int IMAX   = (1 << I_BITS) - 1;
    localparam int NEVER  = 100000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          compared_value = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [3:0]    chan_en = 4'hF;
    logic [1:0]    mux_sel;
    logic          discharge, busy, result_valid, result_ovf, scan_done;
    logic [1:0]    result_chan;
    logic [RW-1:0] results;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adc_scan_scheduler #(.N(N), .I_BITS(I_BITS), .DISCHARGE_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .compared_value (compared_value),
        .start          (start),
        .continuous     (continuous),
        .chan_en        (chan_en),
        .mux_sel        (mux_sel),
        .discharge      (discharge),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_chan    (result_chan),
        .result_ovf     (result_ovf),
        .scan_done      (scan_done),
        .results        (results)
    );

    // Sensor model: thr[ch] ticks after the ramp starts the cap crosses the
    // sensor level (thr 0 = already above; late delays the crossing by two
    // clocks so it lands on the next tick).
    int thr[4];
    bit late[4];
    int cyc = 0;
    int ramp_ticks = 0;
    int since = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
        if (discharge) begin
            ramp_ticks = 0;
            since = 0;
        end else begin
            if (ramp_ticks >= thr[mux_sel]) since++;
            if (tick) ramp_ticks++;
        end
        compared_value = (thr[mux_sel] == 0) ||
                         (!discharge && ramp_ticks >= thr[mux_sel] &&
                          since >= (late[mux_sel] ? 2 : 0));
    end

    typedef struct {
        int ch;
        int val;
        int ovf;
        int done;
    } ev_t;

    ev_t        evq[$];
    logic [3:0] visited = 4'd0;
    int         exp_res[4];

    function automatic int res_of(logic [RW-1:0] r, int ch);
        logic [RW-1:0] t;
        t = r >> (ch * N);
        return (ch == 3) ? int'(t[I_BITS-1:0]) : int'(t[N-1:0]);
    endfunction

    always @(negedge clk) begin
        if (result_valid === 1'b1)
            evq.push_back('{int'(result_chan), res_of(results, int'(result_chan)),
                            int'(result_ovf), int'(scan_done)});
        if (busy === 1'b1 && discharge === 1'b0) visited[mux_sel] = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(logic [3:0] en);
        evq.delete();
        visited = 4'd0;
        chan_en = en;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_events(string tag, int n);
        int b;
        b = 0;
        while (evq.size() < n && b < 5000) begin
            step();
            b++;
        end
        chk(tag, evq.size() >= n, 1);
    endtask

    // Wait for the scan to finish, then compare every stored result and the
    // whole results bus against the threshold model.
    task automatic finish_scan(string tag, logic [3:0] en);
        int   budget;
        int   nexp;
        int   last;
        int   mx;
        int   v;
        ev_t  e;
        budget = 0;
        nexp = 0;
        last = 0;
        while (busy !== 1'b0 && budget < 20000) begin
            step();
            budget++;
        end
        chk($sformatf("%s idle", tag), busy, 0);
        for (int ch = 0; ch < 4; ch++)
            if (en[ch]) begin
                nexp++;
                last = ch;
            end
        chk($sformatf("%s nres", tag), evq.size(), nexp);
        for (int ch = 0; ch < 4; ch++) begin
            if (en[ch]) begin
                mx = (ch == 3) ? IMAX : NMAX;
                v = (thr[ch] > mx) ? mx : thr[ch];
                exp_res[ch] = v;
                if (evq.size() > 0) begin
                    e = evq.pop_front();
                    chk($sformatf("%s chan", tag), e.ch, ch);
                    chk($sformatf("%s val ch%0d", tag, ch), e.val, v);
                    chk($sformatf("%s ovf ch%0d", tag, ch), e.ovf, (thr[ch] > mx) ? 1 : 0);
                    chk($sformatf("%s done ch%0d", tag, ch), e.done, (ch == last) ? 1 : 0);
                end
            end
        end
        chk($sformatf("%s visited", tag), visited, en);
        for (int ch = 0; ch < 4; ch++)
            chk($sformatf("%s results ch%0d", tag, ch), res_of(results, ch), exp_res[ch]);
    endtask

    initial begin
        int b;
        logic [3:0] en;
        for (int ch = 0; ch < 4; ch++) begin
            thr[ch] = 5;
            late[ch] = 1'b0;
            exp_res[ch] = 0;
        end

        // Reset held with start asserted
        start = 1'b1;
        repeat (3) step();
        chk("rst discharge", discharge, 1);
        chk("rst busy", busy, 0);
        chk("rst results", results, 0);
        chk("rst valid", result_valid, 0);
        chk("rst mux", mux_sel, 0);
        chk("rst done", scan_done, 0);
        start = 1'b0;
        reset = 1'b0;
        repeat (6) step();
        chk("post-rst busy", busy, 0);
        chk("post-rst no result", evq.size(), 0);

        // All channels, comparator after 5 ticks each
        launch(4'hF);
        chk("start busy", busy, 1);
        finish_scan("all5", 4'hF);
        repeat (3) step();
        chk("all5 stays idle", busy, 0);

        // Random enables, thresholds and crossing timing
        for (int it = 0; it < 5; it++) begin
            en = 4'($urandom_range(1, 15));
            for (int ch = 0; ch < 4; ch++) begin
                thr[ch] = $urandom_range(1, 12);
                late[ch] = 1'($urandom_range(0, 1));
            end
            launch(en);
            finish_scan($sformatf("rand%0d", it), en);
        end

        // Sparse enables; enables changed and start pulsed mid-scan
        for (int ch = 0; ch < 4; ch++) begin
            thr[ch] = $urandom_range(1, 12);
            late[ch] = 1'b0;
        end
        launch(4'b1010);
        wait_events("sparse first", 1);
        chan_en = 4'b0101;
        start = 1'b1;
        step();
        start = 1'b0;
        finish_scan("sparse1010", 4'b1010);
        launch(4'b0101);
        finish_scan("next0101", 4'b0101);

        // Full-scale saturation on red and intensity
        thr[0] = NEVER;
        thr[3] = NEVER;
        launch(4'b1001);
        finish_scan("ovf", 4'b1001);

        // Intensity right at and one past full scale
        thr[3] = IMAX;
        launch(4'b1000);
        finish_scan("int63", 4'b1000);
        thr[3] = IMAX + 1;
        launch(4'b1000);
        finish_scan("int64", 4'b1000);

        // Comparator already high at ramp start; crossing lands on a tick
        thr[1] = 0;
        thr[2] = 5;
        late[2] = 1'b1;
        launch(4'b0110);
        finish_scan("zero_late", 4'b0110);

        // Continuous mode aborted by reset during blue's ramp
        for (int ch = 0; ch < 4; ch++) begin
            thr[ch] = $urandom_range(1, 8);
            late[ch] = 1'b0;
        end
        chan_en = 4'hF;
        continuous = 1'b1;
        b = 0;
        while (!(busy === 1'b1 && mux_sel === 2'd2 && discharge === 1'b0) && b < 5000) begin
            step();
            b++;
        end
        chk("cont reach ch2 ramp", mux_sel, 2);
        reset = 1'b1;
        step();
        chk("abort discharge", discharge, 1);
        chk("abort busy", busy, 0);
        chk("abort results", results, 0);
        chk("abort valid", result_valid, 0);
        chk("abort mux", mux_sel, 0);
        evq.delete();
        visited = 4'd0;
        for (int ch = 0; ch < 4; ch++) exp_res[ch] = 0;
        reset = 1'b0;
        wait_events("cont restart", 1);
        continuous = 1'b0;
        finish_scan("cont_end", 4'hF);
        repeat (8) step();
        chk("cont stays idle", busy, 0);
        chk("cont no extra result", evq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
